// File: rtl/am_duty_feeder_pkg.sv
// Shared constants and types for the AM duty feeder.
package am_duty_feeder_pkg;

  localparam int unsigned AM_PWM_STEPS_DEFAULT = 50;
  localparam int unsigned CARRIER_DUTY_DEFAULT = AM_PWM_STEPS_DEFAULT / 2;
  localparam int unsigned MOD_FRAC_W           = 8;
  localparam int unsigned MOD_W                = 8;
  localparam int unsigned DUTY_W               = 6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/am_duty_feeder_sample_fifo.sv
// Synchronous show-ahead FIFO with occupancy level and synchronous flush.
module am_duty_feeder_sample_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data_c,
  output logic [$clog2(DEPTH):0]     level,
  output logic [$clog2(DEPTH):0]     level_nxt_c,
  output logic                       full_c,
  output logic                       empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full_c    = (level == LW'(DEPTH));
  assign empty_c   = (level == '0);
  assign push_ok   = push && !full_c;
  assign pop_ok    = pop && !empty_c;
  assign rd_data_c = mem[rd_ptr];

  assign level_nxt_c = flush ? '0 : (level + LW'(push_ok) - LW'(pop_ok));

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      level <= level_nxt_c;
    end
  end

  // Storage needs no reset; occupancy tracking guards every read.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/am_duty_feeder.sv
// Buffers audio samples and emits one clamped AM duty word per PWM symbol tick.
module am_duty_feeder
  import am_duty_feeder_pkg::*;
#(
  parameter int unsigned AM_PWM_STEPS = AM_PWM_STEPS_DEFAULT,
  parameter int unsigned CARRIER_DUTY = AM_PWM_STEPS / 2,
  parameter int unsigned SAMPLE_W     = 8,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic                           symb_tick,
  input  logic signed [SAMPLE_W-1:0]     s_data,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [MOD_W-1:0]               mod_index,
  output logic [DUTY_W-1:0]              duty,
  output logic                           duty_valid,
  output logic                           underrun,
  output logic                           overflow,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level
);

  localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PROD_W = SAMPLE_W + MOD_W + 1;
  localparam int unsigned SUM_W  = PROD_W + 1;

  state_e state_q, state_d;
  logic flush_c, push_c, tick_c, pop_c, ovf_set_c, unr_set_c;
  logic fifo_full_c, fifo_empty_c;
  logic [SAMPLE_W-1:0] head_c;
  logic [LVL_W-1:0]    level_nxt_c;

  logic signed [SAMPLE_W-1:0] sample_c;
  logic signed [PROD_W-1:0]   prod_q;
  logic                       prod_valid_q;
  logic signed [SUM_W-1:0]    sum_c;
  logic [DUTY_W-1:0]          duty_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Leaving RUN takes effect in the same cycle enable drops.
  always_comb begin
    state_d   = state_q;
    flush_c   = 1'b0;
    push_c    = 1'b0;
    tick_c    = 1'b0;
    pop_c     = 1'b0;
    ovf_set_c = 1'b0;
    unr_set_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        flush_c = 1'b1;
        if (enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!enable) begin
          state_d = ST_IDLE;
          flush_c = 1'b1;
        end else begin
          push_c    = s_valid && s_ready && !fifo_full_c;
          tick_c    = symb_tick;
          pop_c     = symb_tick && !fifo_empty_c;
          ovf_set_c = s_valid && !s_ready;
          unr_set_c = symb_tick && fifo_empty_c;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  am_duty_feeder_sample_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush_c),
    .push        (push_c),
    .pop         (pop_c),
    .wr_data     (s_data),
    .rd_data_c   (head_c),
    .level       (fifo_level),
    .level_nxt_c (level_nxt_c),
    .full_c      (fifo_full_c),
    .empty_c     (fifo_empty_c)
  );

  // Registered from next-state values so it equals (level < depth) in RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) s_ready <= 1'b0;
    else      s_ready <= (state_d == ST_RUN) && (level_nxt_c < LVL_W'(FIFO_DEPTH));
  end

  // An underrun tick pushes a zero sample, giving the bare carrier duty.
  assign sample_c = pop_c ? $signed(head_c) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_q       <= '0;
      prod_valid_q <= 1'b0;
    end else if (flush_c) begin
      prod_q       <= '0;
      prod_valid_q <= 1'b0;
    end else begin
      prod_valid_q <= tick_c;
      if (tick_c) prod_q <= PROD_W'(sample_c) * PROD_W'($signed({1'b0, mod_index}));
    end
  end

  always_comb begin
    sum_c  = $signed(SUM_W'(CARRIER_DUTY)) + SUM_W'(prod_q >>> MOD_FRAC_W);
    duty_c = DUTY_W'(sum_c);
    if (sum_c[SUM_W-1])                              duty_c = '0;
    else if (sum_c > $signed(SUM_W'(AM_PWM_STEPS)))  duty_c = DUTY_W'(AM_PWM_STEPS);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      duty       <= '0;
      duty_valid <= 1'b0;
    end else if (flush_c) begin
      duty       <= '0;
      duty_valid <= 1'b0;
    end else begin
      duty_valid <= prod_valid_q;
      if (prod_valid_q) duty <= duty_c;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      underrun <= 1'b0;
      overflow <= 1'b0;
    end else if (flush_c) begin
      underrun <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (unr_set_c) underrun <= 1'b1;
      if (ovf_set_c) overflow <= 1'b1;
    end
  end

endmodule
